// File: rtl/bin_timer_pkg.sv
// Shared types, default sizing and helpers for the binary down-timer.
package bin_timer_pkg;

    localparam int unsigned DEF_WIDTH = 4;
    localparam int unsigned DEF_MAX   = 14;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } timer_state_e;

    // Clamp a requested reload value to the largest legal value.
    function automatic int unsigned sat(input int unsigned x, input int unsigned max);
        return (x > max) ? max : x;
    endfunction

endpackage

// File: rtl/bin_down_timer_if.sv
// Control/status bundle of bin_down_timer.
// Optional macro BIN_DOWN_TIMER_STICKY_EN adds the tc_sticky status bit.
interface bin_down_timer_if #(
    parameter int unsigned WIDTH = 4
) ();

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;
`ifdef BIN_DOWN_TIMER_STICKY_EN
    logic             tc_sticky;

    modport master (
        output load, load_val, start, en, auto_reload,
        input  count, tc, busy, done, tc_sticky
    );

    modport slave (
        input  load, load_val, start, en, auto_reload,
        output count, tc, busy, done, tc_sticky
    );
`else
    modport master (
        output load, load_val, start, en, auto_reload,
        input  count, tc, busy, done
    );

    modport slave (
        input  load, load_val, start, en, auto_reload,
        output count, tc, busy, done
    );
`endif

endinterface

// File: rtl/bin_down_timer.sv
// Loadable binary down-counter/timer with one-shot and periodic modes.
// Optional macro BIN_DOWN_TIMER_STICKY_EN adds a sticky terminal-count flag.
module bin_down_timer
    import bin_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned MAX   = DEF_MAX
) (
    input logic             clk,
    input logic             rst,
    bin_down_timer_if.slave tif
);

    timer_state_e     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] load_sat;
    logic             start_ok;

    assign load_sat = WIDTH'(sat(32'(tif.load_val), MAX));
    // A start is only honoured when no load competes and the timer is not already running.
    assign start_ok = tif.start && !tif.load && (state_q != RUN);

    // Next-state for FSM and counter datapath, priority load > start > en.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        if (tif.load) begin
            reload_d = load_sat;
            count_d  = load_sat;
            state_d  = IDLE;
        end else if (start_ok) begin
            count_d = reload_q;
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (tif.en) begin
                        if (count_q != '0) begin
                            count_d = count_q - WIDTH'(1);
                        end else begin
                            tc_d = 1'b1;
                            if (tif.auto_reload) begin
                                count_d = reload_q;
                            end else begin
                                state_d = DONE;
                            end
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= WIDTH'(MAX);
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign tif.count = count_q;
    assign tif.tc    = tc_q;
    assign tif.busy  = (state_q == RUN);
    assign tif.done  = (state_q == DONE);

`ifdef BIN_DOWN_TIMER_STICKY_EN
    logic sticky_q, sticky_d;

    // Sticky flag: a terminal count on the same edge beats a clearing load/start.
    always_comb begin
        sticky_d = sticky_q;
        if (tif.load || start_ok) begin
            sticky_d = 1'b0;
        end
        if (tc_d) begin
            sticky_d = 1'b1;
        end
    end

    // Sticky flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign tif.tc_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_bin_down_timer.sv
// Self-checking bench for bin_down_timer: directed table, hand sequences, random vs model.
module tb_bin_down_timer;

    localparam int unsigned W   = 4;
    localparam int unsigned MAXV = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bin_down_timer_if #(.WIDTH(W)) tif ();

    bin_down_timer #(.WIDTH(W), .MAX(MAXV)) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: phase 0 idle, 1 running, 2 finished.
    int m_cnt, m_rel, m_phase;
    bit m_tc, m_sticky;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply the rules for one edge given the inputs currently driven.
    task automatic model_edge();
        if (rst) begin
            m_cnt = 0; m_rel = MAXV; m_tc = 0; m_phase = 0; m_sticky = 0;
        end else if (tif.load) begin
            m_rel = (int'(tif.load_val) > MAXV) ? MAXV : int'(tif.load_val);
            m_cnt = m_rel; m_phase = 0; m_tc = 0; m_sticky = 0;
        end else if (tif.start && m_phase != 1) begin
            m_cnt = m_rel; m_phase = 1; m_tc = 0; m_sticky = 0;
        end else if (m_phase == 1 && tif.en) begin
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1; m_tc = 0;
            end else begin
                m_tc = 1; m_sticky = 1;
                if (tif.auto_reload) m_cnt = m_rel;
                else m_phase = 2;
            end
        end else begin
            m_tc = 0;
        end
    endtask

    // One clock edge, then compare every output against the model.
    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, ".count"}, int'(tif.count), m_cnt);
        chk({tag, ".tc"},    int'(tif.tc),    int'(m_tc));
        chk({tag, ".busy"},  int'(tif.busy),  int'(m_phase == 1));
        chk({tag, ".done"},  int'(tif.done),  int'(m_phase == 2));
`ifdef BIN_DOWN_TIMER_STICKY_EN
        chk({tag, ".sticky"}, int'(tif.tc_sticky), int'(m_sticky));
`endif
    endtask

    task automatic drive(input bit r, input bit ld, input int lv, input bit st,
                         input bit e, input bit ar);
        rst = r; tif.load = ld; tif.load_val = W'(lv); tif.start = st;
        tif.en = e; tif.auto_reload = ar;
    endtask

    typedef struct {
        bit r, ld; int lv; bit st, e, ar;
        int cnt; bit tc, busy, done, sticky;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int pulses;
        drive(1, 0, 0, 0, 0, 0);

        // Directed table: inputs for one edge and the outputs required after it.
        tbl.push_back('{1,0, 0,0,0,0,  0,0,0,0,0});
        tbl.push_back('{0,1, 3,0,0,0,  3,0,0,0,0});
        tbl.push_back('{0,0, 0,1,0,0,  3,0,1,0,0});
        tbl.push_back('{0,0, 0,0,1,0,  2,0,1,0,0});
        tbl.push_back('{0,0, 0,0,1,0,  1,0,1,0,0});
        tbl.push_back('{0,0, 0,0,1,0,  0,0,1,0,0});
        tbl.push_back('{0,0, 0,0,1,0,  0,1,0,1,1});
        tbl.push_back('{0,0, 0,0,1,0,  0,0,0,1,1});
        tbl.push_back('{0,1,15,0,0,0, 14,0,0,0,0});
        tbl.push_back('{0,1, 0,0,0,1,  0,0,0,0,0});
        tbl.push_back('{0,0, 0,1,0,1,  0,0,1,0,0});
        tbl.push_back('{0,0, 0,0,1,1,  0,1,1,0,1});
        tbl.push_back('{0,0, 0,0,1,1,  0,1,1,0,1});
        tbl.push_back('{0,0, 0,0,0,1,  0,0,1,0,1});
        tbl.push_back('{0,1, 7,1,0,0,  7,0,0,0,0});
        tbl.push_back('{0,0, 0,1,1,0,  7,0,1,0,0});
        tbl.push_back('{1,0, 0,0,1,0,  0,0,0,0,0});
        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].e, tbl[i].ar);
            cycle($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.cnt", i),  int'(tif.count), tbl[i].cnt);
            chk($sformatf("tbl%0d.tc", i),   int'(tif.tc),    int'(tbl[i].tc));
            chk($sformatf("tbl%0d.busy", i), int'(tif.busy),  int'(tbl[i].busy));
            chk($sformatf("tbl%0d.done", i), int'(tif.done),  int'(tbl[i].done));
`ifdef BIN_DOWN_TIMER_STICKY_EN
            chk($sformatf("tbl%0d.stk", i), int'(tif.tc_sticky), int'(tbl[i].sticky));
`endif
        end

        // Reset for 3 cycles, then default reload MAX counts all the way down.
        drive(1, 0, 0, 0, 0, 0);
        repeat (3) cycle("rst");
        drive(0, 0, 0, 1, 1, 0);
        cycle("rst_start");
        chk("rst_start_max", int'(tif.count), 14);
        drive(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 14; i++) begin
            cycle("rst_down");
            chk("rst_down_val", int'(tif.count), 13 - i);
        end
        cycle("rst_tc");
        chk("rst_tc_pulse", int'(tif.tc), 1);
        cycle("rst_tc_end");
        chk("rst_tc_single", int'(tif.tc), 0);

        // Periodic reload 2: four pulses in 12 enabled cycles.
        drive(0, 1, 2, 0, 0, 1);
        cycle("per_load");
        drive(0, 0, 0, 1, 0, 1);
        cycle("per_start");
        drive(0, 0, 0, 0, 1, 1);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            cycle("per_run");
            pulses += int'(tif.tc);
            chk("per_busy", int'(tif.busy), 1);
        end
        chk("per_pulses", pulses, 4);

        // Mid-run hold with en low, then load+start together.
        drive(0, 1, 9, 0, 0, 0);
        cycle("hold_load");
        drive(0, 0, 0, 1, 0, 0);
        cycle("hold_start");
        drive(0, 0, 0, 0, 1, 0);
        repeat (4) cycle("hold_dn");
        chk("hold_at5", int'(tif.count), 5);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle("hold_en0");
            chk("hold_cnt", int'(tif.count), 5);
        end
        drive(0, 1, 7, 1, 1, 0);
        cycle("hold_ldst");
        chk("ldst_cnt", int'(tif.count), 7);
        chk("ldst_busy", int'(tif.busy), 0);

        // Reset mid-run aborts without a tc pulse.
        drive(0, 0, 0, 1, 1, 0);
        cycle("abort_start");
        drive(0, 0, 0, 0, 1, 0);
        repeat (2) cycle("abort_run");
        drive(1, 0, 0, 0, 1, 0);
        cycle("abort_rst");
        chk("abort_cnt", int'(tif.count), 0);
        chk("abort_tc", int'(tif.tc), 0);
        chk("abort_busy", int'(tif.busy), 0);

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(99) < 2);
            tif.load = ($urandom_range(99) < 6);
            tif.load_val = W'($urandom_range(15));
            tif.start = ($urandom_range(99) < 12);
            tif.en = ($urandom_range(99) < 75);
            if ($urandom_range(99) < 5) tif.auto_reload = ~tif.auto_reload;
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_down_timer.md
Name: bin_down_timer

Overview:
Loadable binary down-counter/timer: the count-down counterpart of the team's free-running 4-bit up-counter.
- Counts from a programmed reload value down to 0.
- Signals terminal count with a one-cycle pulse.
- Either stops (one-shot) or reloads (periodic).
- Used as a delay/interval generator next to the up-counters in the same clock domain.

Parameters:
WIDTH, 4, counter and load-value width in bits
MAX, 14, largest legal reload value; load values above MAX saturate to MAX (matches the 0..14 range of the up-counter)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
load  input  1  capture load_val into reload register and count; forces IDLE
load_val  input  WIDTH  reload value to capture
start  input  1  begin counting from the reload value
en  input  1  count enable, decrement only when high
auto_reload  input  1  1 = periodic (reload at terminal count), 0 = one-shot
count  output  WIDTH  current count, registered
tc  output  1  terminal-count pulse, registered, one cycle wide
busy  output  1  high in RUN
done  output  1  high in DONE (one-shot finished)

Behaviour:
- Reset (rst=1 at clock edge):
  - count=0, reload_reg=MAX, tc=0, state=IDLE, so busy=0 and done=0.
  - Takes effect at the first edge and holds while rst=1.
- Priority per edge: rst > load > start > en.
- States:
  - IDLE: count holds.
  - RUN: counting.
  - DONE: count holds at 0.
- busy and done decode directly from the state register; they carry no extra latency.
- load, any state:
  - reload_reg<=sat(load_val) and count<=sat(load_val), where sat(x)=min(x,MAX).
  - state<=IDLE, tc<=0.
  - A start in the same cycle is ignored.
- start, IDLE or DONE, no load: count<=reload_reg, state<=RUN, tc<=0. No decrement on that edge, even if en=1.
- start in RUN: ignored.
- RUN with en=1:
  - count!=0: count<=count-1, tc<=0.
  - count==0: tc<=1. If auto_reload=1, count<=reload_reg and stay RUN. Else count stays 0 and state<=DONE.
- RUN with en=0: count and state hold, tc<=0.
- auto_reload is sampled only at the count==0 edge. Changing it mid-run takes effect at the next terminal count.
- Period: reload_reg+1 enabled cycles per tc pulse.
  - reload_reg=0 with auto_reload=1 gives tc=1 on every enabled cycle (tc may stay high on consecutive cycles).
- tc is low on every edge that does not meet the terminal condition.
- Arithmetic is unsigned WIDTH-bit. The counter never decrements below 0; there is no wrap to all-ones.
- rst during RUN: abort to the reset state on that edge; no tc is generated.

Optional Feature:
BIN_DOWN_TIMER_STICKY_EN
- Defined:
  - Adds output tc_sticky (1 bit).
  - Set on any edge where tc is set.
  - Cleared by rst, load or an accepted start. Set wins over clear if both occur on the same edge.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package bin_timer_pkg holds:
  - state typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Default WIDTH/MAX localparams.
  - Saturation function sat().
- Single module; no sub-module is warranted. The counter datapath and FSM share one always block per register group.

Test Plan:
1. rst=1 for 3 cycles, then 0 -> count=0, tc=0, busy=0, done=0; reload_reg=MAX verified by start with en=1: count 14,13,...,0, then tc.
2. load_val=3, load; start; en=1, auto_reload=0 -> count 3,2,1,0 on successive edges; tc=1 for exactly one cycle on the next edge with done=1, busy=0; count holds 0.
3. load_val=2, auto_reload=1, start, en=1 for 12 cycles -> count 2,1,0,2,1,0,...; tc pulse every 3rd cycle, 4 pulses; busy stays 1, done 0.
4. load_val=15 (>MAX) -> count=14 after load; start then count from 14. Also load_val=0 with auto_reload=1 -> tc high every enabled cycle.
5. Mid-run (count=5), hold en=0 for 4 cycles -> count stays 5, tc=0. Then assert load=1 with load_val=7 and start=1 together -> state IDLE, count=7, busy=0.
6. Mid-run, assert rst for 1 cycle -> next edge count=0, tc=0, busy=0, no tc pulse. With BIN_DOWN_TIMER_STICKY_EN, tc_sticky=1 after test 2 and clears on the next start.
